// File: rtl/dds_voice_ctrl_if.sv
// Host command bus and voice-bank output bundle of the DDS voice controller.
interface dds_voice_ctrl_if #(
    parameter int NV = 3,
    parameter int TW = 16,
    parameter int SW = 3
);
    logic             wr_stb;
    logic [7:0]       wr_data;
    logic             err;
    logic [NV*TW-1:0] tw_out;
    logic [NV*SW-1:0] sel_out;
    logic [NV-1:0]    en_out;

    modport master (output wr_stb, wr_data, input  err, tw_out, sel_out, en_out);
    modport slave  (input  wr_stb, wr_data, output err, tw_out, sel_out, en_out);
endinterface

// File: rtl/dds_voice_ctrl.sv
// Byte-serial configuration controller for the DDS voice bank, with a
// time-multiplexed glide engine stepping each voice's tuning word toward its target.
module dds_voice_ctrl #(
    parameter int NV    = 3,
    parameter int TW    = 16,
    parameter int SW    = 3,
    parameter int PRE_W = 10,
    parameter int TO_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    dds_voice_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;
    typedef enum logic [1:0] {
        OP_SET_TW   = 2'b00,
        OP_SET_SEL  = 2'b01,
        OP_SET_RATE = 2'b10,
        OP_ALL_OFF  = 2'b11
    } op_t;

    // Last idle count before the frame is abandoned: 2^TO_W-1 silent cycles in total.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
    localparam logic [2:0]      NV_L    = 3'(NV);

    state_t          state_q, state_d;
    op_t             op_q;
    logic [1:0]      voice_q;
    logic [7:0]      hi_q;
    logic [TO_W-1:0] to_q, to_d;
    logic            timeout, frame_done, all_off;
    logic            voice_ok, commit, collide;

    logic [TW-1:0]   cur_q  [NV];
    logic [TW-1:0]   tgt_q  [NV];
    logic [7:0]      rate_q [NV];
    logic [SW-1:0]   sel_q  [NV];
    logic [NV-1:0]   en_q;
    logic            err_q;

    logic [PRE_W-1:0] pre_q;
    logic             sw_act_q;
    logic [1:0]       sw_idx_q;

    logic [TW-1:0] cur_s, tgt_s, rate_s, diff_s, step_s;
    logic          up_s;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_d    = state_q;
        to_d       = '0;
        timeout    = 1'b0;
        frame_done = 1'b0;
        all_off    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.wr_stb) begin
                    if (bus.wr_data[7:6] == OP_ALL_OFF) all_off = 1'b1;
                    else                                state_d = S_HI;
                end
            end
            S_HI, S_LO: begin
                if (bus.wr_stb) begin
                    if (state_q == S_HI) begin
                        state_d = S_LO;
                    end else begin
                        state_d    = S_IDLE;
                        frame_done = 1'b1;
                    end
                end else if (to_q == TO_LAST) begin
                    state_d = S_IDLE;
                    timeout = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_SET_TW;
            voice_q <= '0;
            hi_q    <= '0;
        end else begin
            if (state_q == S_IDLE && bus.wr_stb) begin
                op_q    <= op_t'(bus.wr_data[7:6]);
                voice_q <= bus.wr_data[5:4];
            end
            if (state_q == S_HI && bus.wr_stb) hi_q <= bus.wr_data;
        end
    end

    assign voice_ok = ({1'b0, voice_q} < NV_L);
    assign commit   = frame_done && voice_ok;
    // A host write to the voice in its sweep slot takes priority over the glide step.
    assign collide  = commit && sw_act_q && (voice_q == sw_idx_q);

    always_comb begin
        cur_s  = cur_q[sw_idx_q];
        tgt_s  = tgt_q[sw_idx_q];
        rate_s = TW'(rate_q[sw_idx_q]);
        up_s   = (cur_s < tgt_s);
        diff_s = up_s ? (tgt_s - cur_s) : (cur_s - tgt_s);
        if (diff_s <= rate_s) step_s = tgt_s;
        else                  step_s = up_s ? (cur_s + rate_s) : (cur_s - rate_s);
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the per-voice arrays are flops, not RAM, so each element is reset explicitly.
        if (rst) begin
            for (int v = 0; v < NV; v++) begin
                cur_q[v]  <= '0;
                tgt_q[v]  <= '0;
                rate_q[v] <= '0;
                sel_q[v]  <= '0;
            end
            en_q     <= '0;
            err_q    <= 1'b0;
            pre_q    <= '0;
            sw_act_q <= 1'b0;
            sw_idx_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
            if (pre_q == '1) begin
                sw_act_q <= 1'b1;
                sw_idx_q <= '0;
            end else if (sw_act_q) begin
                if (sw_idx_q == 2'(NV-1)) sw_act_q <= 1'b0;
                else                      sw_idx_q <= sw_idx_q + 1'b1;
            end

            if (sw_act_q && !collide) cur_q[sw_idx_q] <= step_s;

            if (commit) begin
                case (op_q)
                    OP_SET_TW: begin
                        tgt_q[voice_q] <= TW'({hi_q, bus.wr_data});
                        if (rate_q[voice_q] == 8'd0) cur_q[voice_q] <= TW'({hi_q, bus.wr_data});
                    end
                    OP_SET_SEL: begin
                        sel_q[voice_q] <= bus.wr_data[SW-1:0];
                        en_q[voice_q]  <= bus.wr_data[7];
                    end
                    OP_SET_RATE: rate_q[voice_q] <= bus.wr_data;
                    default: ;
                endcase
            end
            if (all_off) en_q <= '0;

            err_q <= timeout || (frame_done && !voice_ok);
        end
    end

    logic [NV*TW-1:0] tw_flat;
    logic [NV*SW-1:0] sel_flat;

    always_comb begin
        tw_flat  = '0;
        sel_flat = '0;
        for (int v = 0; v < NV; v++) begin
            tw_flat[v*TW +: TW]  = cur_q[v];
            sel_flat[v*SW +: SW] = sel_q[v];
        end
    end

    assign bus.tw_out  = tw_flat;
    assign bus.sel_out = sel_flat;
    assign bus.en_out  = en_q;
    assign bus.err     = err_q;
endmodule
